// File: rtl/pito_boot_loader.sv
// Frames a UART byte stream (A5, target, length, payload, XOR checksum) into
// little-endian 32-bit words and writes them to the imem or dmem external port.
module pito_boot_loader #(
  parameter int IMEM_AW = 12,
  parameter int DMEM_AW = 12,
  parameter int TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               imem_req,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [3:0]         imem_be,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic [3:0]         dmem_be,
  output logic               pito_program,
  output logic               busy,
  output logic               load_done,
  output logic               load_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TGT  = 3'd1;
  localparam logic [2:0] S_LEN0 = 3'd2;
  localparam logic [2:0] S_LEN1 = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [16:0] IMEM_DEPTH = 17'(32'd1 << IMEM_AW);
  localparam logic [16:0] DMEM_DEPTH = 17'(32'd1 << DMEM_AW);
  localparam int          GAP_W      = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [15:0]      len_q, len_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       xor_q, xor_d;
  logic [15:0]      idx_q, idx_d;
  logic             wr_q, wr_d;
  logic             prog_q, prog_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic        in_frame;
  logic [16:0] n_len;
  logic [16:0] depth_sel;

  assign in_frame  = (state_q != S_IDLE) && (state_q != S_ERR);
  assign n_len     = {1'b0, rx_data, len_q[7:0]};
  assign depth_sel = tgt_q ? DMEM_DEPTH : IMEM_DEPTH;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    xor_d   = xor_q;
    idx_d   = wr_q ? idx_q + 16'd1 : idx_q;
    wr_d    = 1'b0;
    prog_d  = prog_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    gap_d   = '0;

    if (in_frame && !rx_valid) begin
      gap_d = gap_q + 1'b1;
    end

    // ERR lasts one cycle; a byte arriving in it is handled as if in IDLE
    if (state_q == S_ERR) begin
      state_d = S_IDLE;
      prog_d  = 1'b0;
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (rx_data == 8'hA5) begin
            state_d = S_TGT;
            cnt_d   = 2'd0;
            xor_d   = 8'h00;
            idx_d   = 16'd0;
          end
        end
        S_TGT: begin
          if (rx_data[7:1] == 7'd0) begin
            tgt_d   = rx_data[0];
            prog_d  = 1'b1;
            state_d = S_LEN0;
          end else begin
            state_d = S_ERR;
          end
        end
        S_LEN0: begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = rx_data;
          if (n_len > depth_sel) begin
            state_d = S_ERR;
          end else if (n_len == 17'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d[{cnt_q, 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_d = 1'b1;
            // The final word's write pulse overlaps the first CHK cycle
            if (idx_q + 16'd1 == len_q) begin
              state_d = S_CHK;
            end
          end
        end
        S_CHK: begin
          state_d = S_IDLE;
          prog_d  = 1'b0;
          if (rx_data == xor_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (in_frame && gap_q == GAP_LAST) begin
      state_d = S_ERR;
    end

    if (state_d == S_ERR) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= 1'b0;
      len_q   <= 16'd0;
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      xor_q   <= 8'd0;
      idx_q   <= 16'd0;
      wr_q    <= 1'b0;
      prog_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      prog_q  <= prog_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  assign imem_req   = wr_q & ~tgt_q;
  assign imem_we    = imem_req;
  assign imem_be    = {4{imem_req}};
  assign imem_addr  = imem_req ? idx_q[IMEM_AW-1:0] : '0;
  assign imem_wdata = imem_req ? word_q : 32'd0;

  assign dmem_req   = wr_q & tgt_q;
  assign dmem_we    = dmem_req;
  assign dmem_be    = {4{dmem_req}};
  assign dmem_addr  = dmem_req ? idx_q[DMEM_AW-1:0] : '0;
  assign dmem_wdata = dmem_req ? word_q : 32'd0;

  assign pito_program = prog_q;
  assign busy         = (state_q != S_IDLE);
  assign load_done    = done_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_pito_boot_loader.sv
// Directed bench for pito_boot_loader: small memories (8 words) and a short
// timeout so the length boundary and the stall abort are cheap to reach.
module tb_pito_boot_loader;

  localparam int AW = 3;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          imem_req, imem_we, dmem_req, dmem_we;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_wdata, dmem_wdata;
  logic [3:0]    imem_be, dmem_be;
  logic          pito_program, busy, load_done, load_error;

  pito_boot_loader #(.IMEM_AW(AW), .DMEM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_req(imem_req), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_be(imem_be),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .pito_program(pito_program), .busy(busy),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Write / pulse monitor
  int          cyc = 0;
  int          done_n = 0;
  int          err_n = 0;
  int          done_cyc = 0;
  logic [31:0] im_addr[$], im_data[$], im_ctl[$];
  logic [31:0] dm_addr[$], dm_data[$], dm_ctl[$];
  int          im_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (imem_req) begin
      im_addr.push_back(32'(imem_addr));
      im_data.push_back(imem_wdata);
      im_ctl.push_back(32'({imem_we, imem_be}));
      im_cyc.push_back(cyc);
    end
    if (dmem_req) begin
      dm_addr.push_back(32'(dmem_addr));
      dm_data.push_back(dmem_wdata);
      dm_ctl.push_back(32'({dmem_we, dmem_be}));
    end
    if (load_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (load_error) err_n <= err_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b_im, b_dm, b_done, b_err;
    logic [7:0]  x;
    logic [7:0]  bt[4];
    logic [31:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'({imem_req, imem_we, imem_be, dmem_req, dmem_we, dmem_be,
                          pito_program, busy, load_done, load_error}), 64'd0);
    chk("reset_data", 64'({imem_wdata, dmem_wdata}), 64'd0);
    rst = 1'b0;

    // Garbage in IDLE is ignored
    b_im = im_addr.size(); b_dm = dm_addr.size(); b_done = done_n; b_err = err_n;
    send(8'h11); send(8'h22); idle(3);
    chk("garbage_busy", 64'(busy), 64'd0);
    chk("garbage_writes", 64'(im_addr.size() + dm_addr.size() - b_im - b_dm), 64'd0);
    chk("garbage_pulses", 64'(done_n + err_n - b_done - b_err), 64'd0);

    // imem load, N=2, full-rate byte stream
    b_im = im_addr.size(); b_dm = dm_addr.size(); b_done = done_n;
    send(8'hA5); send(8'h00); send(8'h02);
    chk("imem_prog_after_tgt", 64'(pito_program), 64'd1);
    chk("imem_busy", 64'(busy), 64'd1);
    send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
    send(8'h7C);
    chk("imem_prog_in_chk", 64'(pito_program), 64'd1);
    idle(1);
    chk("imem_done_pulse", 64'(load_done), 64'd1);
    chk("imem_prog_cleared", 64'(pito_program), 64'd0);
    idle(1);
    chk("imem_done_one_cycle", 64'(load_done), 64'd0);
    chk("imem_done_count", 64'(done_n - b_done), 64'd1);
    chk("imem_write_count", 64'(im_addr.size() - b_im), 64'd2);
    chk("imem_dmem_quiet", 64'(dm_addr.size() - b_dm), 64'd0);
    chk("imem_w0_addr", 64'(im_addr[b_im]), 64'd0);
    chk("imem_w0_data", 64'(im_data[b_im]), 64'h13);
    chk("imem_w0_we_be", 64'(im_ctl[b_im]), 64'h1F);
    chk("imem_w1_addr", 64'(im_addr[b_im+1]), 64'd1);
    chk("imem_w1_data", 64'(im_data[b_im+1]), 64'h6F);
    chk("imem_w1_we_be", 64'(im_ctl[b_im+1]), 64'h1F);
    chk("imem_word_spacing", 64'(im_cyc[b_im+1] - im_cyc[b_im]), 64'd4);
    chk("imem_done_after_write", 64'(done_cyc - im_cyc[b_im+1]), 64'd1);

    // dmem load, N=1, bad checksum (correct would be 0x08)
    b_im = im_addr.size(); b_dm = dm_addr.size(); b_done = done_n; b_err = err_n;
    send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'h00);
    idle(1);
    chk("dmem_error_pulse", 64'(load_error), 64'd1);
    chk("dmem_no_done", 64'(load_done), 64'd0);
    idle(1);
    chk("dmem_error_one_cycle", 64'(load_error), 64'd0);
    chk("dmem_idle", 64'(busy), 64'd0);
    chk("dmem_write_count", 64'(dm_addr.size() - b_dm), 64'd1);
    chk("dmem_w0_addr", 64'(dm_addr[b_dm]), 64'd0);
    chk("dmem_w0_data", 64'(dm_data[b_dm]), 64'h12345678);
    chk("dmem_w0_we_be", 64'(dm_ctl[b_dm]), 64'h1F);
    chk("dmem_imem_quiet", 64'(im_addr.size() - b_im), 64'd0);
    chk("dmem_pulse_counts", 64'({done_n - b_done, err_n - b_err}), {32'd0, 32'd1});

    // Invalid target byte
    b_err = err_n;
    send(8'hA5); send(8'h02); idle(1);
    chk("badtgt_error", 64'(load_error), 64'd1);
    chk("badtgt_prog", 64'(pito_program), 64'd0);
    idle(1);
    chk("badtgt_idle", 64'(busy), 64'd0);

    // Length one above depth
    b_im = im_addr.size(); b_dm = dm_addr.size();
    send(8'hA5); send(8'h00); send(8'h09); send(8'h00); idle(1);
    chk("badlen_error", 64'(load_error), 64'd1);
    idle(1);
    chk("badlen_idle", 64'({busy, pito_program}), 64'd0);
    chk("badlen_no_writes", 64'(im_addr.size() + dm_addr.size() - b_im - b_dm), 64'd0);
    chk("bad_frames_error_count", 64'(err_n - b_err), 64'd2);

    // Length exactly equal to depth fills addresses 0..7
    b_im = im_addr.size(); b_done = done_n;
    send(8'hA5); send(8'h00); send(8'h08); send(8'h00);
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bt[0] = 8'(i + 1); bt[1] = 8'(8'h20 + i); bt[2] = 8'hC3; bt[3] = 8'(i * 3);
      for (int k = 0; k < 4; k++) begin
        send(bt[k]);
        x = x ^ bt[k];
      end
    end
    send(x);
    idle(1);
    chk("full_done", 64'(load_done), 64'd1);
    idle(1);
    chk("full_write_count", 64'(im_addr.size() - b_im), 64'd8);
    for (int i = 0; i < 8; i++) begin
      w = {8'(i * 3), 8'hC3, 8'(8'h20 + i), 8'(i + 1)};
      chk($sformatf("full_w%0d_addr", i), 64'(im_addr[b_im+i]), 64'(i));
      chk($sformatf("full_w%0d_data", i), 64'(im_data[b_im+i]), 64'(w));
    end

    // Stall mid-word until the inter-byte timeout fires
    b_im = im_addr.size(); b_dm = dm_addr.size(); b_err = err_n;
    send(8'hA5); send(8'h00); send(8'h01); send(8'h00); send(8'hAA);
    idle(TO - 10);
    chk("stall_still_busy", 64'(busy), 64'd1);
    chk("stall_no_early_error", 64'(err_n - b_err), 64'd0);
    idle(20);
    chk("timeout_error_count", 64'(err_n - b_err), 64'd1);
    chk("timeout_idle", 64'({busy, pito_program}), 64'd0);
    chk("timeout_no_writes", 64'(im_addr.size() + dm_addr.size() - b_im - b_dm), 64'd0);

    // N=0 frame followed with zero gap by an N=1 frame
    b_im = im_addr.size(); b_done = done_n;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); send(8'h22);
    idle(1);
    chk("b2b_second_done", 64'(load_done), 64'd1);
    idle(1);
    chk("b2b_done_count", 64'(done_n - b_done), 64'd2);
    chk("b2b_write_count", 64'(im_addr.size() - b_im), 64'd1);
    chk("b2b_addr_restart", 64'(im_addr[b_im]), 64'd0);
    chk("b2b_data", 64'(im_data[b_im]), 64'hDEADBEEF);

    // Reset after the 2nd payload byte
    b_im = im_addr.size(); b_dm = dm_addr.size(); b_done = done_n;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    idle(1);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({imem_req, dmem_req, imem_be, dmem_be, pito_program,
                               busy, load_done, load_error}), 64'd0);
    idle(2);
    rst = 1'b0;

    // Reset landing on the pending-write cycle drops the write
    send(8'hA5); send(8'h00); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_no_partial_write", 64'(im_addr.size() + dm_addr.size() - b_im - b_dm), 64'd0);

    // Clean frame after reset: checksum 04^03^02^01 = 04
    send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
    send(8'h04); send(8'h03); send(8'h02); send(8'h01); send(8'h04);
    idle(1);
    chk("postrst_done", 64'(load_done), 64'd1);
    idle(1);
    chk("postrst_done_count", 64'(done_n - b_done), 64'd1);
    chk("postrst_write_count", 64'(dm_addr.size() - b_dm), 64'd1);
    chk("postrst_addr", 64'(dm_addr[b_dm]), 64'd0);
    chk("postrst_data", 64'(dm_data[b_dm]), 64'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pito_boot_loader.md
# pito_boot_loader

Byte-stream program loader that sits upstream of the SoC's external memory ports. It consumes bytes from a UART receiver, frames them into a load packet, and assembles little-endian 32-bit words. It writes those words through the external instruction-memory or data-memory port. While a load is in progress it holds the core in program mode.

## Interface
Parameters:
- IMEM_AW, 12: instruction memory word-address width; depth 2**IMEM_AW words.
- DMEM_AW, 12: data memory word-address width; depth 2**DMEM_AW words.
- TIMEOUT, 100000: maximum clk cycles allowed between bytes inside a frame.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- imem_req  out  1  imem external-port request.
- imem_we  out  1  imem write enable.
- imem_addr  out  IMEM_AW  imem word address.
- imem_wdata  out  32  imem write data.
- imem_be  out  4  imem byte enables.
- dmem_req, dmem_we, dmem_addr (DMEM_AW), dmem_wdata (32), dmem_be (4): the same set of signals for data memory.
- pito_program  out  1  high while a frame is being loaded; holds the core.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse when a frame completes with a good checksum.
- load_error  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Frame format, in byte order:
  - 0xA5 (magic);
  - target: 0x00 selects imem, 0x01 selects dmem;
  - LEN_LO, LEN_HI: word count N, 16-bit little-endian;
  - N×4 payload bytes, each word little-endian;
  - CHK: the XOR of all payload bytes.
- FSM states:
  - IDLE: wait for magic. A non-0xA5 byte is ignored silently.
  - TGT: accept 0x00 or 0x01; any other byte goes to ERR.
  - LEN0: capture LEN_LO.
  - LEN1: capture LEN_HI. If N > depth of the selected memory, go to ERR. If N == 0, go to CHK. Otherwise go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into word[8*k+:8]. The running XOR accumulates each byte.
  - CHK: compare the received byte with the XOR accumulator. A match pulses load_done; a mismatch pulses load_error. Return to IDLE in both cases.
  - ERR: pulse load_error for one cycle, then go to IDLE.
- Word write path:
  - The 4th byte of a word sets write_pending.
  - On the next cycle, the selected port drives req=1, we=1, be=4'hF, addr=word_idx, wdata=assembled word, for exactly one cycle.
  - word_idx then increments. word_idx starts at 0 for every frame.
  - The other port's req stays 0.
  - The write is a side pulse, not an FSM state. The FSM stays in DATA, so a byte arriving in the write cycle is accepted.
- After word N is written, the FSM moves to CHK.
- pito_program: set on acceptance of a valid target byte; cleared when leaving CHK or ERR.
- Timeout: the gap counter resets on every rx_valid and counts only in TGT, LEN0, LEN1, DATA and CHK. Reaching TIMEOUT forces ERR.
- Data already written to memory before an abort is not rolled back.

## Timing
- Reset values of all outputs are 0, including pito_program, busy, pulses and all req/we/be. FSM resets to IDLE.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronous).
  - No partial write is issued.
  - A pending write is dropped.
- State transitions happen on the clk edge where rx_valid=1.
- Write latency: req asserts on the cycle after the rx_valid of the 4th byte of the word.
- load_done / load_error rise on the cycle after the CHK byte, or the cycle after ERR entry; each lasts exactly 1 cycle.
- The last word's write completes before or in the same cycle as the FSM enters CHK, so load_done never precedes the final write.
- If timeout and rx_valid occur in the same cycle, rx_valid wins and the counter resets.
- Length check at the exact boundary: N == 2**AW is accepted and writes up to address 2**AW-1. N == 2**AW+1 goes to ERR.
- An rx_valid in the load_done or load_error cycle is processed by IDLE. 0xA5 in that cycle starts a new frame.

## Test plan
- imem load, N=2: send A5 00 02 00 / 13 00 00 00 / 6F 00 00 00 / 7C -> imem writes addr0=0x00000013 then addr1=0x0000006F, each a single-cycle req with be=F; load_done pulses once; pito_program is high from the TGT byte through CHK.
- dmem load, N=1, bad checksum: send A5 01 01 00 / 78 56 34 12 / 00 -> dmem addr0=0x12345678 is written; load_error pulses; load_done stays 0.
- Invalid target and length: send A5 02 -> load_error, back to IDLE. Send A5 00 LEN = 2**IMEM_AW+1 -> load_error with no writes issued.
- Timeout and garbage: send 11 22 in IDLE -> no response. Send A5 00 01 00 AA then stall TIMEOUT cycles -> load_error, and no write is issued.
- N=0 and back-to-back frames: send A5 00 00 00 00 -> load_done, no writes. Immediately send a second frame with 0 idle cycles -> it is accepted and word_idx restarts at 0.
- Reset mid-frame: assert rst after the 2nd payload byte -> all outputs are 0. A full frame sent after reset release loads correctly.
